// File: rtl/bcd_stopwatch_timer.sv
`default_nettype none
// ============================================================================
// Module   : bcd_stopwatch_timer
// Brief    : Four-digit BCD stopwatch/timer (SS.hh) with toggle start/pause.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_stopwatch_timer #(
    parameter int TICK_DIV = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       toggle,
    input  logic [1:0] mode,
    input  logic [7:0] sw,
    output logic [3:0] reg_d0,
    output logic [3:0] reg_d1,
    output logic [3:0] reg_d2,
    output logic [3:0] reg_d3,
    output logic       running,
    output logic       done
);

    localparam int             c_cw   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(TICK_DIV - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_pause = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_toggle_q;
    logic [c_cw-1:0] r_presc;
    logic            r_down;
    logic [15:0]     r_digits;

    logic            w_tog_edge;
    logic            w_tick;
    logic [3:0]      w_sw_hi;
    logic [3:0]      w_sw_lo;
    logic [15:0]     w_start;
    logic            w_start_term;
    logic [15:0]     w_step;
    logic            w_step_term;
    logic            w_carry;

    assign w_tog_edge = toggle & ~r_toggle_q;
    assign w_tick     = (r_state == c_st_run) && (r_presc == c_last);

    assign w_sw_hi = (sw[7:4] > 4'd9) ? 4'd9 : sw[7:4];
    assign w_sw_lo = (sw[3:0] > 4'd9) ? 4'd9 : sw[3:0];

    always_comb begin
        w_start = 16'h0000;
        case (mode)
            2'b00:   w_start = 16'h0000;
            2'b10:   w_start = 16'h9999;
            default: w_start = {w_sw_hi, w_sw_lo, 8'h00};
        endcase
    end

    assign w_start_term = mode[1] ? (w_start == 16'h0000) : (w_start == 16'h9999);

    // Ripple a +/-1 through the four digits; the terminal check stops d3 from wrapping.
    always_comb begin
        w_step  = r_digits;
        w_carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_carry) begin
                if (!r_down) begin
                    if (r_digits[i*4 +: 4] == 4'd9) begin
                        w_step[i*4 +: 4] = 4'd0;
                    end else begin
                        w_step[i*4 +: 4] = r_digits[i*4 +: 4] + 4'd1;
                        w_carry          = 1'b0;
                    end
                end else begin
                    if (r_digits[i*4 +: 4] == 4'd0) begin
                        w_step[i*4 +: 4] = 4'd9;
                    end else begin
                        w_step[i*4 +: 4] = r_digits[i*4 +: 4] - 4'd1;
                        w_carry          = 1'b0;
                    end
                end
            end
        end
    end

    assign w_step_term = r_down ? (w_step == 16'h0000) : (w_step == 16'h9999);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_tog_edge) begin
                    w_state_nxt = w_start_term ? c_st_done : c_st_run;
                end
            end
            c_st_run: begin
                if (w_tog_edge) begin
                    w_state_nxt = c_st_pause;
                end else if (w_tick && w_step_term) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_pause: begin
                if (w_tog_edge) begin
                    w_state_nxt = c_st_run;
                end
            end
            c_st_done: w_state_nxt = c_st_done;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A toggle edge in RUN wins over a coincident tick: no count, prescaler holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_toggle_q <= 1'b0;
            r_presc    <= '0;
            r_digits   <= w_start;
            r_down     <= mode[1];
        end else begin
            r_toggle_q <= toggle;
            case (r_state)
                c_st_idle: begin
                    r_presc  <= '0;
                    r_digits <= w_start;
                    r_down   <= mode[1];
                end
                c_st_run: begin
                    if (!w_tog_edge) begin
                        if (w_tick) begin
                            r_presc  <= '0;
                            r_digits <= w_step;
                        end else begin
                            r_presc <= r_presc + c_cw'(1);
                        end
                    end
                end
                c_st_pause: r_presc <= r_presc;
                default:    r_presc <= '0;
            endcase
        end
    end

    assign reg_d0  = r_digits[3:0];
    assign reg_d1  = r_digits[7:4];
    assign reg_d2  = r_digits[11:8];
    assign reg_d3  = r_digits[15:12];
    assign running = (r_state == c_st_run);
    assign done    = (r_state == c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_bcd_stopwatch_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_stopwatch_timer
// Brief    : Scoreboard bench for bcd_stopwatch_timer with TICK_DIV = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_stopwatch_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       toggle;
    logic [1:0] mode;
    logic [7:0] sw;
    logic [3:0] reg_d0, reg_d1, reg_d2, reg_d3;
    logic       running, done;

    int total = 0;
    int bad   = 0;

    logic [17:0] exp_q[$];
    string       name_q[$];
    logic [17:0] r_exp, r_act;
    string       r_nm;
    logic        inv_en = 1'b0;

    bcd_stopwatch_timer #(.TICK_DIV(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .toggle  (toggle),
        .mode    (mode),
        .sw      (sw),
        .reg_d0  (reg_d0),
        .reg_d1  (reg_d1),
        .reg_d2  (reg_d2),
        .reg_d3  (reg_d3),
        .running (running),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic expect_out(input string nm, input logic [15:0] dg, input logic run, input logic dn);
        exp_q.push_back({dg, run, dn});
        name_q.push_back(nm);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        toggle = 1'b1;
        step(1);
        toggle = 1'b0;
    endtask

    // Monitor: compares queued expectations against outputs on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (inv_en) begin
                total++;
                if (reg_d0 > 4'd9 || reg_d1 > 4'd9 || reg_d2 > 4'd9 || reg_d3 > 4'd9) begin
                    bad++;
                    $display("FAIL bcd_range: got digits=%h%h.%h%h, required each digit 0-9",
                             reg_d3, reg_d2, reg_d1, reg_d0);
                end
            end
            while (exp_q.size() > 0) begin
                r_exp = exp_q.pop_front();
                r_nm  = name_q.pop_front();
                r_act = {reg_d3, reg_d2, reg_d1, reg_d0, running, done};
                total++;
                if (r_act !== r_exp) begin
                    bad++;
                    $display("FAIL %s: got digits=%h run=%b done=%b, required digits=%h run=%b done=%b",
                             r_nm, r_act[17:2], r_act[1], r_act[0], r_exp[17:2], r_exp[1], r_exp[0]);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        toggle = 1'b0;
        mode   = 2'b00;
        sw     = 8'h00;
        step(2);
        reset  = 1'b0;
        inv_en = 1'b1;
        expect_out("reset_state", 16'h0000, 1'b0, 1'b0);

        // Count up, pause, hold
        pulse();
        step(48);
        expect_out("up_12_ticks", 16'h0012, 1'b1, 1'b0);
        pulse();
        expect_out("paused", 16'h0012, 1'b0, 1'b0);
        step(50);
        expect_out("pause_hold", 16'h0012, 1'b0, 1'b0);

        // Preset carry and clamping
        reset = 1'b1; mode = 2'b01; sw = 8'h59;
        step(1);
        reset = 1'b0;
        expect_out("preset_59", 16'h5900, 1'b0, 1'b0);
        pulse();
        step(396);
        expect_out("preset_5999", 16'h5999, 1'b1, 1'b0);
        step(4);
        expect_out("carry_6000", 16'h6000, 1'b1, 1'b0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        sw = 8'h37;
        step(1);
        expect_out("idle_track_37", 16'h3700, 1'b0, 1'b0);
        sw = 8'hFF;
        step(1);
        expect_out("clamp_ff", 16'h9900, 1'b0, 1'b0);
        sw = 8'hA3;
        step(1);
        expect_out("clamp_a3", 16'h9300, 1'b0, 1'b0);

        // Countdown to terminal
        mode = 2'b11; sw = 8'h01;
        step(1);
        expect_out("down_preset_01", 16'h0100, 1'b0, 1'b0);
        pulse();
        step(396);
        expect_out("down_0001", 16'h0001, 1'b1, 1'b0);
        step(4);
        expect_out("down_done", 16'h0000, 1'b0, 1'b1);
        pulse();
        step(3);
        pulse();
        step(20);
        expect_out("done_ignores_toggle", 16'h0000, 1'b0, 1'b1);

        // Down from 99.99 with multi-digit borrow
        reset = 1'b1; mode = 2'b10;
        step(1);
        reset = 1'b0;
        expect_out("down_start_9999", 16'h9999, 1'b0, 1'b0);
        pulse();
        step(4);
        expect_out("down_first_tick", 16'h9998, 1'b1, 1'b0);
        step(4 * 998);
        expect_out("down_9000", 16'h9000, 1'b1, 1'b0);
        step(4);
        expect_out("borrow_8999", 16'h8999, 1'b1, 1'b0);

        // Start value equals terminal value
        reset = 1'b1; mode = 2'b11; sw = 8'h00;
        step(1);
        reset = 1'b0;
        expect_out("zero_preset_idle", 16'h0000, 1'b0, 1'b0);
        pulse();
        expect_out("immediate_done", 16'h0000, 1'b0, 1'b1);
        mode = 2'b00; sw = 8'h55;
        step(5);
        expect_out("done_mode_change", 16'h0000, 1'b0, 1'b1);

        // Toggle coincident with tick, held toggle
        reset = 1'b1; mode = 2'b00;
        step(1);
        reset = 1'b0;
        pulse();
        step(3);
        expect_out("pre_tick", 16'h0000, 1'b1, 1'b0);
        toggle = 1'b1;
        step(1);
        expect_out("tick_vs_toggle", 16'h0000, 1'b0, 1'b0);
        toggle = 1'b0;
        step(9);
        expect_out("pause_frozen", 16'h0000, 1'b0, 1'b0);
        toggle = 1'b1;
        step(20);
        expect_out("held_toggle", 16'h0005, 1'b1, 1'b0);
        toggle = 1'b0;

        // Reset mid-run
        reset = 1'b1; mode = 2'b01; sw = 8'h12;
        step(1);
        reset = 1'b0;
        pulse();
        step(136);
        expect_out("run_1234", 16'h1234, 1'b1, 1'b0);
        mode  = 2'b00;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        expect_out("reset_mid_run", 16'h0000, 1'b0, 1'b0);
        step(3);
        expect_out("idle_after_reset", 16'h0000, 1'b0, 1'b0);

        step(2);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_stopwatch_timer.md
Name: bcd_stopwatch_timer

Overview:
- Four-digit BCD stopwatch/timer core, format SS.hh (00.00–99.99).
- Sits directly upstream of the hex-to-7-segment decoders and the display multiplexer, driving reg_d3..reg_d0.
- Runs on the single board clock and derives its own 0.01 s count tick internally.
- A toggle button starts and pauses it; mode and sw select the count direction and the preset.

Parameters:
- TICK_DIV, 1000000: clk cycles per count tick (100 MHz → 100 Hz). Range is 1 or more. Benches use 4.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- toggle  input  1  start/pause button, already debounced and synchronous to clk; acts on its rising edge only
- mode  input  2  00 up from 00.00; 01 up from preset; 10 down from 99.99; 11 down from preset
- sw  input  8  preset seconds: sw[7:4] tens digit, sw[3:0] units digit; each nibble above 9 is clamped to 9
- reg_d0  output  4  hundredths digit (BCD)
- reg_d1  output  4  tenths digit
- reg_d2  output  4  seconds units digit
- reg_d3  output  4  seconds tens digit
- running  output  1  high in RUN
- done  output  1  high in DONE

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE; prescaler=0; toggle edge register=0; running=0; done=0.
  - Digits load the start value of the current mode.
- Start values:
  - mode 00: 00.00
  - mode 01 and 11: {clamp(sw[7:4]), clamp(sw[3:0])}.00
  - mode 10: 99.99
- Mode latch: mode is latched on the IDLE→RUN transition. Changes to mode or sw in RUN, PAUSE or DONE are ignored.
- Toggle edge: tog_edge = toggle & ~toggle_q. toggle_q is registered every cycle. A held toggle produces exactly one edge.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; tick is asserted when the count equals TICK_DIV-1.
  - Holds its value in PAUSE.
  - Clears in IDLE and DONE.
  - Result: the first tick occurs TICK_DIV cycles after entering RUN.
- IDLE:
  - Digits track the start value every cycle.
  - tog_edge → RUN, unless start value == terminal value, in which case → DONE.
  - No count happens in the cycle of the transition.
- RUN:
  - tog_edge → PAUSE. This has priority: a tick in the same cycle is dropped and the prescaler holds.
  - Otherwise, on tick the value changes by ±1 hundredth with BCD carry/borrow:
    - Up: d0 9→0 carries into d1, d1 9→0 into d2, d2 9→0 into d3.
    - Down: d0 0→9 borrows from d1, and so on.
  - Terminal value: 99.99 for up modes, 00.00 for down modes. The edge that produces it also enters DONE. There is no wrap-around.
- PAUSE:
  - Digits frozen.
  - tog_edge → RUN; the prescaler resumes from its held value.
- DONE:
  - Digits hold the terminal value.
  - toggle is ignored.
  - Exit only via reset.
- Reset mid-operation: returns to IDLE with digits at the current mode's start value on that edge.
- Output timing:
  - All outputs are registered.
  - A digit update is visible the cycle after the tick cycle.
  - running/done change on the same edge as the state.
- Invariants: every digit is always 0–9; no non-BCD value is ever output.

Test Plan (TICK_DIV=4):
1. reset, mode=00, toggle pulse, run 4×12 cycles → digits 00.12, running=1; second toggle pulse → running=0; digits hold 00.12 for 50 cycles.
2. mode=01, sw=8'h59, preset carry: run to 59.99, next tick → 60.00. sw=8'hFF in IDLE → digits 99.00.
3. mode=11, sw=8'h01 → 01.00; start; after 100 ticks → 00.00, done=1, running=0; further toggles and ticks leave 00.00.
4. mode=10: start at 99.99; the first tick gives 99.98. At 90.00 the next tick gives 89.99 (multi-digit borrow).
5. mode=11, sw=8'h00, toggle → DONE immediately, digits 00.00, done=1. Changing mode to 00 in DONE → no change.
6. Toggle edge coincident with tick in RUN → pauses with no count. Toggle held high 20 cycles → exactly one transition. Reset asserted mid-RUN at 12.34 with mode=00 → next edge digits 00.00, state IDLE.
